// File: rtl/smg_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment vectors here are active-high {dp,g,f,e,d,c,b,a}; polarity is applied at the outputs.
package smg_pkg;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_OFF = 8'h00;

  // Ceiling log2 with a floor of 1 so single-value counters still get a bit
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  // Hex nibble to segment pattern, dp left off
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0:    s = 8'h3F;
      4'h1:    s = 8'h06;
      4'h2:    s = 8'h5B;
      4'h3:    s = 8'h4F;
      4'h4:    s = 8'h66;
      4'h5:    s = 8'h6D;
      4'h6:    s = 8'h7D;
      4'h7:    s = 8'h07;
      4'h8:    s = 8'h7F;
      4'h9:    s = 8'h6F;
      4'hA:    s = 8'h77;
      4'hB:    s = 8'h7C;
      4'hC:    s = 8'h39;
      4'hD:    s = 8'h5E;
      4'hE:    s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/smg_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_HZ/SCAN_HZ clocks.
module smg_tick_gen
  import smg_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = clog2(DIV);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_W'(DIV - 1));

  // Count 0..DIV-1 and wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered loading,
// per-digit decimal points, leading-zero blanking and a frame-start strobe.
// Optional build macro SMG_BLINK_EN adds a per-digit blink mask.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_blank,
  input  logic                    load,
`ifdef SMG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   smg_sig,
  output logic [7:0]              smg_data,
  output logic                    frame_start
);

  localparam int unsigned            IDX_W    = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                   SEG_POL  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0]  DIG_POL  = DIG_ACTIVE_LOW ? '1 : '0;

  logic                         tick_c;
  logic                         boundary_c;
  logic [IDX_W-1:0]             idx;

  logic [NUM_DIGITS-1:0][3:0]   stg_data;
  logic [NUM_DIGITS-1:0]        stg_dp;
  logic                         stg_lz;
  logic                         pending;
  logic [NUM_DIGITS-1:0][3:0]   sh_data;
  logic [NUM_DIGITS-1:0]        sh_dp;
  logic                         sh_lz;

  logic [NUM_DIGITS-1:0]        blank_vec;
  logic                         all_zero;
  logic [3:0]                   nib_c;
  seg_t                         seg_c;
  logic [NUM_DIGITS-1:0]        sig_c;

`ifdef SMG_BLINK_EN
  localparam int unsigned BLINK_RAW    = SCAN_HZ / (2 * NUM_DIGITS);
  localparam int unsigned BLINK_FRAMES = (BLINK_RAW < 1) ? 1 : BLINK_RAW;
  localparam int unsigned BF_W         = clog2(BLINK_FRAMES);

  logic [NUM_DIGITS-1:0]        stg_blink;
  logic [NUM_DIGITS-1:0]        sh_blink;
  logic [BF_W-1:0]              fcnt;
  logic                         phase;
`endif

  smg_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk    (clk_50MHz),
    .rst    (rst),
    .tick_c (tick_c)
  );

  assign boundary_c = tick_c && (idx == LAST_IDX);

  // Digit index steps once per tick
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      idx <= '0;
    end else if (tick_c) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // Staging takes every load; shadow only changes at a frame boundary so a frame is never torn
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      stg_data <= '0;
      stg_dp   <= '0;
      stg_lz   <= 1'b0;
      pending  <= 1'b0;
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_lz    <= 1'b0;
    end else if (boundary_c) begin
      pending <= 1'b0;
      if (load) begin
        sh_data <= data;
        sh_dp   <= dp_mask;
        sh_lz   <= lz_blank;
      end else if (pending) begin
        sh_data <= stg_data;
        sh_dp   <= stg_dp;
        sh_lz   <= stg_lz;
      end
    end else if (load) begin
      stg_data <= data;
      stg_dp   <= dp_mask;
      stg_lz   <= lz_blank;
      pending  <= 1'b1;
    end
  end

`ifdef SMG_BLINK_EN
  // Blink mask follows the same staging/shadow path as the display data
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      stg_blink <= '0;
      sh_blink  <= '0;
    end else if (boundary_c) begin
      if (load) begin
        sh_blink <= blink_mask;
      end else if (pending) begin
        sh_blink <= stg_blink;
      end
    end else if (load) begin
      stg_blink <= blink_mask;
    end
  end

  // Blink phase flips every BLINK_FRAMES frames
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary_c) begin
      if (fcnt == BF_W'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + BF_W'(1);
      end
    end
  end
`endif

  // Leading-zero blank flags: digit k blanks when it and everything above it is zero
  always_comb begin
    blank_vec = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero & (sh_data[k] == 4'h0);
      blank_vec[k] = sh_lz & all_zero & (k != 0);
    end
  end

  // Segment and digit-enable patterns for the digit being selected
  always_comb begin
    nib_c          = sh_data[idx];
    seg_c          = blank_vec[idx] ? SEG_OFF : hex_to_seg(nib_c);
    seg_c[SEG_DP]  = sh_dp[idx];
`ifdef SMG_BLINK_EN
    if (phase && sh_blink[idx]) begin
      seg_c = SEG_OFF;
    end
`endif
    sig_c      = '0;
    sig_c[idx] = 1'b1;
  end

  // Registered pin drive with polarity applied; outputs hold between ticks
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      smg_sig     <= DIG_POL;
      smg_data    <= SEG_OFF ^ SEG_POL;
      frame_start <= 1'b0;
    end else if (tick_c) begin
      smg_sig     <= sig_c ^ DIG_POL;
      smg_data    <= seg_c ^ SEG_POL;
      frame_start <= (idx == '0);
    end else begin
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Scoreboard bench for smg_scan_ctrl: 4 digits, DIV=4, active-low segments and digits.
// Build with SMG_BLINK_EN defined to also exercise the blink path.
module tb_smg_scan_ctrl;

  localparam int ND           = 4;
  localparam int DIVC         = 4;
  localparam int FRAME        = ND * DIVC;
  localparam int BLINK_FRAMES = 31;

  localparam logic [7:0] SEG_AL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [3:0] sig;
    logic [7:0] seg;
    logic       fs;
    logic [7:0] digit;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = '0;
  logic [3:0]  dp_mask = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
`ifdef SMG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [3:0]  smg_sig;
  logic [7:0]  smg_data;
  logic        frame_start;

  int   n_checks = 0;
  int   n_errors = 0;
  int   k = 0;
  exp_t exp_q[$];
  exp_t last;

  smg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .CLK_HZ         (1000),
    .SCAN_HZ        (250),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_50MHz   (clk),
    .rst         (rst),
    .data        (data),
    .dp_mask     (dp_mask),
    .lz_blank    (lz_blank),
    .load        (load),
`ifdef SMG_BLINK_EN
    .blink_mask  (blink_mask),
`endif
    .smg_sig     (smg_sig),
    .smg_data    (smg_data),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected active-low segment byte for one digit
  function automatic logic [7:0] exp_seg(input logic [15:0] d, input logic [3:0] dp,
                                         input logic lz, input logic off, input int digit);
    logic [15:0] upper;
    logic [7:0]  s;
    if (off) return 8'hFF;
    upper = d >> (4 * digit);
    s = (lz && digit != 0 && upper == 16'h0) ? 8'hFF : SEG_AL[upper[3:0]];
    if (dp[digit]) s[7] = 1'b0;
    return s;
  endfunction

  // Queue the four digit drives of one frame
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dp, input logic lz,
                            input logic [3:0] bmask, input logic phase);
    exp_t e;
    for (int i = 0; i < ND; i++) begin
      e.digit  = 8'(i);
      e.sig    = 4'hF;
      e.sig[i] = 1'b0;
      e.seg    = exp_seg(d, dp, lz, phase & bmask[i], i);
      e.fs     = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    data     = d;
    dp_mask  = dp;
    lz_blank = lz;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  // Advance to just after the next frame-boundary edge
  task automatic to_boundary();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((k % FRAME) != 0 && n < 2 * FRAME);
    if ((k % FRAME) != 0) check_eq("boundary_sync", 32'(k % FRAME), 32'd0);
  endtask

  // Edges since reset release; digit drives land on every DIVC-th edge
  always @(posedge clk) k <= rst ? 0 : k + 1;

  always @(negedge clk) begin
    exp_t e;
    if (k == 0) begin
      check_eq("idle_sig", 32'(smg_sig), 32'hF);
      check_eq("idle_seg", 32'(smg_data), 32'hFF);
      check_eq("idle_fs", 32'(frame_start), 32'd0);
      last = '{sig: 4'hF, seg: 8'hFF, fs: 1'b0, digit: 8'd0};
    end else if (k % DIVC == 0) begin
      if (exp_q.size() == 0) begin
        check_eq($sformatf("sb_empty k%0d", k), 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq($sformatf("sig d%0d k%0d", e.digit, k), 32'(smg_sig), 32'(e.sig));
        check_eq($sformatf("seg d%0d k%0d", e.digit, k), 32'(smg_data), 32'(e.seg));
        check_eq($sformatf("fs d%0d k%0d", e.digit, k), 32'(frame_start), 32'(e.fs));
        last = e;
      end
    end else begin
      check_eq($sformatf("hold_sig k%0d", k), 32'(smg_sig), 32'(last.sig));
      check_eq($sformatf("hold_seg k%0d", k), 32'(smg_data), 32'(last.seg));
      check_eq($sformatf("hold_fs k%0d", k), 32'(frame_start), 32'd0);
    end
  end

  initial begin
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // Frame 0 shows the cleared shadow; first load lands at boundary 16
    push_frame(16'h0000, 4'h0, 1'b0, 4'h0, 1'b0);
    do_load(16'h12AF, 4'b0100, 1'b0);
    to_boundary();
    push_frame(16'h12AF, 4'b0100, 1'b0, 4'h0, 1'b0);
    to_boundary();

    // Leading-zero blanking, including a blanked digit with dp lit
    push_frame(16'h12AF, 4'b0100, 1'b0, 4'h0, 1'b0);
    do_load(16'h0050, 4'b0000, 1'b1);
    to_boundary();
    push_frame(16'h0050, 4'b0000, 1'b1, 4'h0, 1'b0);
    do_load(16'h0000, 4'b1000, 1'b1);
    to_boundary();

    // Two loads mid-frame: current frame untouched, only the last one shows
    push_frame(16'h0000, 4'b1000, 1'b1, 4'h0, 1'b0);
    cyc(5);
    do_load(16'h3456, 4'b0011, 1'b0);
    cyc(2);
    do_load(16'h789A, 4'b0001, 1'b0);
    to_boundary();

    // Load coincident with the boundary edge goes straight to the next frame
    push_frame(16'h789A, 4'b0001, 1'b0, 4'h0, 1'b0);
    cyc(FRAME - 1);
    do_load(16'hBEEF, 4'b1010, 1'b0);
    push_frame(16'hBEEF, 4'b1010, 1'b0, 4'h0, 1'b0);
    to_boundary();
    push_frame(16'hBEEF, 4'b1010, 1'b0, 4'h0, 1'b0);
    to_boundary();

    // Reset mid-frame aborts the scan and clears the shadow
    push_frame(16'hBEEF, 4'b1010, 1'b0, 4'h0, 1'b0);
    cyc(6);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    push_frame(16'h0000, 4'h0, 1'b0, 4'h0, 1'b0);

`ifdef SMG_BLINK_EN
    // Digit 0 blinks with the frame-counted phase
    blink_mask = 4'b0001;
    do_load(16'h0000, 4'h0, 1'b0);
    for (int f = 1; f <= 40; f++) begin
      to_boundary();
      push_frame(16'h0000, 4'h0, 1'b0, 4'b0001, ((f / BLINK_FRAMES) % 2) == 1);
    end
    cyc(6);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    push_frame(16'h0000, 4'h0, 1'b0, 4'h0, 1'b0);
    do_load(16'h0000, 4'h0, 1'b0);
    to_boundary();
    push_frame(16'h0000, 4'h0, 1'b0, 4'b0001, 1'b0);
    to_boundary();
`else
    to_boundary();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
